// File: rtl/sigma_rst_seq.sv
`timescale 1ns/1ps
// sigma_rst_seq: reset sequencer between the board PLL and the sigma SoC.
// rst_o is asserted asynchronously by arst_i and released synchronously once
// the synchronized PLL lock has been stable and a hold time has elapsed.
// Optional watchdog: define SIGMA_RST_WDT_EN to build it.
module sigma_rst_seq #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_HOLD_CYCLES    = 64,
  parameter int WDT_CYCLES         = 16777216
) (
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic       pll_locked_i,
  input  logic       sw_rst_req_i,
  input  logic       wdt_kick_i,
  output logic       rst_o,
  output logic [1:0] rst_cause_o,
  output logic [7:0] lock_loss_cnt_o
);

  // One phase counter is shared by STABLE and HOLD, so size it for the longer one.
  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ? LOCK_STABLE_CYCLES
                                                                  : RST_HOLD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_HOLD      = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   lock;

`ifdef SIGMA_RST_WDT_EN
  localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
  localparam logic [WDT_W-1:0] WDT_ONE  = WDT_W'(1);

  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_expire;

  // A kick on the terminal cycle rescues the SoC; only an unkicked terminal cycle fires.
  assign wdt_expire = !wdt_kick_i && (wdt_cnt == WDT_LAST);
`else
  // Watchdog not built: the kick input is deliberately left without a load.
  localparam int unused_wdt_cycles = WDT_CYCLES;
  logic unused_wdt_kick;
  assign unused_wdt_kick = wdt_kick_i;
`endif

  // Bring the asynchronous PLL lock flag into the clk_i domain.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  assign lock = sync[SYNC_STAGES-1];

  // Sequencer FSM; rst_o is registered as "next state is not RUN" so it never glitches.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state           <= ST_RESET;
      cnt             <= '0;
      rst_o           <= 1'b1;
      rst_cause_o     <= 2'd0;
      lock_loss_cnt_o <= 8'd0;
`ifdef SIGMA_RST_WDT_EN
      wdt_cnt         <= '0;
`endif
    end else begin
`ifdef SIGMA_RST_WDT_EN
      // The watchdog only counts in RUN; every other path leaves it cleared.
      wdt_cnt <= '0;
`endif
      case (state)
        ST_RESET: begin
          state <= ST_WAIT_LOCK;
          cnt   <= '0;
          rst_o <= 1'b1;
        end
        ST_WAIT_LOCK: begin
          cnt   <= '0;
          rst_o <= 1'b1;
          if (lock) begin
            state <= ST_STABLE;
          end else begin
            state <= ST_WAIT_LOCK;
          end
        end
        ST_STABLE: begin
          rst_o <= 1'b1;
          if (!lock) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state <= ST_HOLD;
            cnt   <= '0;
          end else begin
            cnt   <= cnt + CNT_ONE;
          end
        end
        ST_HOLD: begin
          // Software requests are ignored here: the hold is already running.
          if (!lock) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
            rst_o <= 1'b1;
          end else if (cnt == HOLD_LAST) begin
            state <= ST_RUN;
            cnt   <= '0;
            rst_o <= 1'b0;
          end else begin
            cnt   <= cnt + CNT_ONE;
            rst_o <= 1'b1;
          end
        end
        ST_RUN: begin
          cnt <= '0;
          if (!lock) begin
            state       <= ST_WAIT_LOCK;
            rst_o       <= 1'b1;
            rst_cause_o <= 2'd1;
            if (lock_loss_cnt_o != 8'hFF) begin
              lock_loss_cnt_o <= lock_loss_cnt_o + 8'd1;
            end else begin
              lock_loss_cnt_o <= lock_loss_cnt_o;
            end
          end else if (sw_rst_req_i) begin
            // Lock is known good, so skip restabilization and go straight to hold.
            state       <= ST_HOLD;
            rst_o       <= 1'b1;
            rst_cause_o <= 2'd2;
`ifdef SIGMA_RST_WDT_EN
          end else if (wdt_expire) begin
            state       <= ST_HOLD;
            rst_o       <= 1'b1;
            rst_cause_o <= 2'd3;
          end else begin
            state   <= ST_RUN;
            rst_o   <= 1'b0;
            wdt_cnt <= wdt_kick_i ? '0 : (wdt_cnt + WDT_ONE);
          end
`else
          end else begin
            state <= ST_RUN;
            rst_o <= 1'b0;
          end
`endif
        end
        default: begin
          state <= ST_RESET;
          cnt   <= '0;
          rst_o <= 1'b1;
        end
      endcase
    end
  end

endmodule
